// File: rtl/rx_comma_align.sv
// Receive-path comma aligner: searches all ten bit offsets of the deserialized
// stream for K28.5, locks after repeated agreement and emits aligned symbols.
module rx_comma_align #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [9:0] rx_data,
    input  logic       realign,
    output logic       aligned_valid,
    output logic [9:0] aligned_data,
    output logic       comma_det,
    output logic       aligned,
    output logic [3:0] offset
);
    // state  | meaning
    // HUNT   | no candidate; waiting for any K28.5
    // VERIFY | counting consecutive K28.5 at offset cand
    // LOCKED | boundary fixed at offset; emitting symbols
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;
    localparam logic [3:0] LOCK_TC   = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_TC   = 4'(LOSS_CNT);

    state_t      state;
    state_t      nxt_state;
    logic [9:0]  prev;
    logic [3:0]  cnt;
    logic [3:0]  miscnt;
    logic [3:0]  cand;
    logic [3:0]  nxt_cnt;
    logic [3:0]  nxt_miscnt;
    logic [3:0]  nxt_cand;
    logic [3:0]  nxt_offset;
    logic [3:0]  cnt_inc;
    logic [3:0]  miscnt_inc;
    logic [18:0] window;
    logic [9:0]  cands [16];
    logic [15:0] hit;
    logic        any_hit;
    logic [3:0]  first_hit;
    logic        emit;

    // rx_data[0] only ever lands in prev, so it never reaches a candidate
    assign window = {prev, rx_data[9:1]};

    for (genvar g = 0; g < 16; g++) begin : g_cand
        if (g < 10) begin : g_live
            assign cands[g] = window[18-g -: 10];
            assign hit[g]   = (cands[g] == K28_5_NEG) || (cands[g] == K28_5_POS);
        end else begin : g_pad
            assign cands[g] = '0;
            assign hit[g]   = 1'b0;
        end
    end

    always_comb begin
        first_hit = '0;
        for (int o = 9; o >= 0; o--) begin
            if (hit[o]) first_hit = 4'(o);
        end
    end

    assign any_hit    = |hit;
    assign cnt_inc    = (cnt == 4'd15) ? cnt : cnt + 4'd1;
    assign miscnt_inc = (miscnt == 4'd15) ? miscnt : miscnt + 4'd1;

    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_miscnt = miscnt;
        nxt_cand   = cand;
        nxt_offset = offset;
        if (realign) begin
            nxt_state  = HUNT;
            nxt_cnt    = '0;
            nxt_miscnt = '0;
        end else if (rx_valid) begin
            case (state)
                HUNT: begin
                    if (any_hit) begin
                        nxt_cand = first_hit;
                        nxt_cnt  = 4'd1;
                        if (LOCK_TC <= 4'd1) begin
                            nxt_state  = LOCKED;
                            nxt_offset = first_hit;
                            nxt_miscnt = '0;
                        end else begin
                            nxt_state = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (hit[cand]) begin
                        nxt_cnt = cnt_inc;
                        if (cnt_inc >= LOCK_TC) begin
                            nxt_state  = LOCKED;
                            nxt_offset = cand;
                            nxt_miscnt = '0;
                        end
                    end else if (any_hit) begin
                        nxt_cand = first_hit;
                        nxt_cnt  = 4'd1;
                    end else begin
                        nxt_state = HUNT;
                        nxt_cnt   = '0;
                    end
                end
                LOCKED: begin
                    if (hit[offset]) begin
                        nxt_miscnt = '0;
                    end else if (any_hit) begin
                        nxt_miscnt = miscnt_inc;
                        // the comma that breaks lock is not reused as a candidate
                        if (miscnt_inc >= LOSS_TC) begin
                            nxt_state  = HUNT;
                            nxt_cnt    = '0;
                            nxt_miscnt = '0;
                        end
                    end
                end
                default: begin
                    nxt_state = HUNT;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    assign emit = rx_valid && !realign && (nxt_state == LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= HUNT;
            prev          <= '0;
            cnt           <= '0;
            miscnt        <= '0;
            cand          <= '0;
            offset        <= '0;
            aligned       <= 1'b0;
            aligned_valid <= 1'b0;
            aligned_data  <= '0;
            comma_det     <= 1'b0;
        end else begin
            state         <= nxt_state;
            cnt           <= nxt_cnt;
            miscnt        <= nxt_miscnt;
            cand          <= nxt_cand;
            offset        <= nxt_offset;
            aligned       <= (nxt_state == LOCKED);
            aligned_valid <= emit;
            comma_det     <= emit && hit[nxt_offset];
            if (rx_valid) prev <= rx_data;
            if (emit) aligned_data <= cands[nxt_offset];
        end
    end
endmodule

// File: tb/tb_rx_comma_align.sv
// Bench for rx_comma_align: directed lock/loss/realign scenarios plus a random
// bit stream, all checked every cycle against a streak-counting reference.
module tb_rx_comma_align;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 4;
    localparam logic [9:0] KN    = 10'h0FA;
    localparam logic [9:0] KP    = 10'h305;
    localparam logic [9:0] D21_5 = 10'h2AA;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [9:0] rx_data = '0;
    logic       realign = 1'b0;
    logic       aligned_valid;
    logic [9:0] aligned_data;
    logic       comma_det;
    logic       aligned;
    logic [3:0] offset;

    int n_checks = 0;
    int n_pass = 0;

    bit bq[$];
    bit rand_mode = 1'b0;
    bit rd_pos = 1'b0;

    // reference model state
    bit         m_locked;
    int         m_streak, m_cand, m_off, m_foreign;
    logic [9:0] m_prev, m_data;
    bit         m_av, m_cd;
    int         wv, first_m;
    int         cv [10];
    bit         hit_m [10];

    rx_comma_align #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .realign(realign), .aligned_valid(aligned_valid), .aligned_data(aligned_data),
        .comma_det(comma_det), .aligned(aligned), .offset(offset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // model: a lock is a streak of LOCK_CNT commas at one offset; lock is lost
    // after LOSS_CNT commas seen only elsewhere
    always @(posedge clk) begin
        if (!rst_n) begin
            m_locked = 0; m_streak = 0; m_cand = 0; m_off = 0; m_foreign = 0;
            m_prev = '0; m_data = '0; m_av = 0; m_cd = 0;
        end else begin
            m_av = 0;
            m_cd = 0;
            if (realign) begin
                m_locked = 0; m_streak = 0; m_foreign = 0;
            end else if (rx_valid) begin
                wv = int'({m_prev, rx_data});
                first_m = -1;
                for (int o = 9; o >= 0; o--) begin
                    cv[o] = (wv >> (10 - o)) & 1023;
                    hit_m[o] = (cv[o] == 250) || (cv[o] == 773);
                    if (hit_m[o]) first_m = o;
                end
                if (m_locked) begin
                    if (hit_m[m_off]) m_foreign = 0;
                    else if (first_m >= 0) begin
                        m_foreign = (m_foreign < 15) ? m_foreign + 1 : 15;
                        if (m_foreign >= LOSS_CNT) begin
                            m_locked = 0; m_streak = 0;
                        end
                    end
                end else if (m_streak > 0 && hit_m[m_cand]) begin
                    m_streak = (m_streak < 15) ? m_streak + 1 : 15;
                    if (m_streak >= LOCK_CNT) begin
                        m_locked = 1; m_off = m_cand; m_foreign = 0;
                    end
                end else if (first_m >= 0) begin
                    m_cand = first_m;
                    m_streak = 1;
                    if (LOCK_CNT <= 1) begin
                        m_locked = 1; m_off = m_cand; m_foreign = 0;
                    end
                end else begin
                    m_streak = 0;
                end
                if (m_locked) begin
                    m_av = 1;
                    m_data = 10'(cv[m_off]);
                    m_cd = hit_m[m_off];
                end
            end
            if (rx_valid) m_prev = rx_data;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("cmp_aligned_valid", aligned_valid, m_av);
        chk("cmp_aligned", aligned, m_locked);
        chk("cmp_offset", offset, m_off);
        chk("cmp_comma_det", comma_det, m_cd);
        chk("cmp_aligned_data", aligned_data, m_data);
    end

    task automatic step(input logic [9:0] w, input bit v, input bit ra);
        @(negedge clk);
        rx_data = w;
        rx_valid = v;
        realign = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic push_sym(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) bq.push_back(s[i]);
    endtask

    task automatic push_fill(input int n);
        for (int i = 0; i < n; i++) bq.push_back((i % 2) == 0);
    endtask

    task automatic push_comma();
        push_sym(rd_pos ? KP : KN);
        rd_pos = !rd_pos;
    endtask

    task automatic refill();
        int r;
        if (!rand_mode) begin
            push_sym(D21_5);
        end else begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                for (int i = 0; i < int'($urandom_range(1, 9)); i++) bq.push_back($urandom_range(0, 1) == 1);
            end else if (r < 60) push_sym($urandom_range(0, 1) == 1 ? KP : KN);
            else if (r < 80) push_sym(D21_5);
            else push_sym(10'($urandom));
        end
    endtask

    task automatic send(input bit ra);
        logic [9:0] w;
        while (bq.size() < 10) refill();
        for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
        step(w, 1'b1, ra);
    endtask

    task automatic gap();
        step(10'($urandom), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rx_valid = 1'b1; realign = 1'b0; rx_data = 10'($urandom);
        @(negedge clk);
        rx_data = 10'($urandom);
        @(posedge clk);
        #1;
        chk("rst_aligned_valid", aligned_valid, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_offset", offset, 0);
        chk("rst_comma_det", comma_det, 0);
        chk("rst_aligned_data", aligned_data, 0);
        @(negedge clk);
        rst_n = 1'b1; rx_valid = 1'b0;
        bq.delete();
        rd_pos = 1'b0;
    endtask

    initial begin
        rand_mode = 1'b0;

        // lock at offset 3 on an alternating comma stream, then data
        do_reset();
        push_fill(3);
        repeat (8) push_comma();
        repeat (4) push_sym(D21_5);
        for (int k = 0; k < 13; k++) begin
            send(1'b0);
            if (k == 3) chk("t1_prelock_aligned", aligned, 0);
            if (k == 4) begin
                chk("t1_lock_aligned", aligned, 1);
                chk("t1_lock_offset", offset, 3);
                chk("t1_lock_data", aligned_data, 10'h305);
                chk("t1_lock_cd", comma_det, 1);
            end
            if (k == 5) begin
                chk("t1_next_data", aligned_data, 10'h0FA);
                chk("t1_next_cd", comma_det, 1);
            end
            if (k == 9) begin
                chk("t1_d21_data", aligned_data, 10'h2AA);
                chk("t1_d21_cd", comma_det, 0);
                chk("t1_d21_av", aligned_valid, 1);
            end
        end

        // verify interrupted by one non-comma at offset 5
        do_reset();
        push_fill(5);
        repeat (3) push_comma();
        push_sym(D21_5);
        repeat (4) push_comma();
        for (int k = 0; k < 10; k++) begin
            send(1'b0);
            if (k == 4) chk("t2_break_aligned", aligned, 0);
            if (k == 7) chk("t2_prelock_aligned", aligned, 0);
            if (k == 8) begin
                chk("t2_lock_aligned", aligned, 1);
                chk("t2_lock_offset", offset, 5);
            end
        end

        // valid gaps during verify at offset 7
        do_reset();
        push_fill(7);
        repeat (4) push_comma();
        send(1'b0);
        send(1'b0);
        send(1'b0);
        gap();
        chk("t3_gap_av", aligned_valid, 0);
        gap();
        chk("t3_gap_av2", aligned_valid, 0);
        send(1'b0);
        chk("t3_prelock_aligned", aligned, 0);
        send(1'b0);
        chk("t3_lock_aligned", aligned, 1);
        chk("t3_lock_offset", offset, 7);
        chk("t3_lock_av", aligned_valid, 1);
        send(1'b0);

        // loss at a foreign offset, with an intervening home comma
        do_reset();
        push_fill(3);
        repeat (6) push_comma();
        push_fill(5);
        repeat (2) push_comma();
        push_fill(5);
        push_sym(KN);
        push_fill(5);
        repeat (8) push_comma();
        for (int k = 0; k < 21; k++) begin
            send(1'b0);
            if (k == 6) chk("t4_locked_aligned", aligned, 1);
            if (k == 8) begin
                chk("t4_foreign_aligned", aligned, 1);
                chk("t4_foreign_cd", comma_det, 0);
            end
            if (k == 10) begin
                chk("t4_home_cd", comma_det, 1);
                chk("t4_home_data", aligned_data, 10'h0FA);
            end
            if (k == 13) chk("t4_3rd_foreign_aligned", aligned, 1);
            if (k == 14) begin
                chk("t4_loss_aligned", aligned, 0);
                chk("t4_loss_av", aligned_valid, 0);
                chk("t4_loss_offset_hold", offset, 3);
            end
            if (k == 17) chk("t4_prerelock_aligned", aligned, 0);
            if (k == 18) begin
                chk("t4_relock_aligned", aligned, 1);
                chk("t4_relock_offset", offset, 8);
            end
        end

        // forced realign while locked at offset 2
        do_reset();
        push_fill(2);
        repeat (12) push_comma();
        for (int k = 0; k < 13; k++) begin
            send(k == 6);
            if (k == 4) chk("t5_lock_offset", offset, 2);
            if (k == 6) begin
                chk("t5_realign_aligned", aligned, 0);
                chk("t5_realign_av", aligned_valid, 0);
                chk("t5_realign_offset_hold", offset, 2);
            end
            if (k == 9) chk("t5_prerelock_aligned", aligned, 0);
            if (k == 10) begin
                chk("t5_relock_aligned", aligned, 1);
                chk("t5_relock_offset", offset, 2);
            end
        end

        // random stream with skew slips, gaps and occasional realign
        do_reset();
        rand_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) send(1'b1);
            else if (r < 14) gap();
            else send(1'b0);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rx_comma_align.md
Name: rx_comma_align

Overview:
- Receive-path symbol aligner that sits directly upstream of the 8b/10b decode stage.
- Accepts unaligned 10-bit parallel words from the deserializer and searches all 10 bit offsets for the K28.5 code group in either disparity.
- Locks onto the offset after repeated consistent detection, then emits boundary-aligned 10-bit symbols (abcdeifghj) for decoding.
- Tracks loss of alignment and supports forced realignment.

Parameters:
- LOCK_CNT, 4: consecutive K28.5 at the same offset required to lock (legal 1..15).
- LOSS_CNT, 4: consecutive K28.5 at a foreign offset that drops lock (legal 1..15).

Ports:
- clk  in  1  receive-path clock
- rst_n  in  1  synchronous active-low reset
- rx_valid  in  1  rx_data carries a new word this cycle
- rx_data  in  10  raw deserializer word; bit 9 received first
- realign  in  1  single-cycle request to drop lock and re-hunt
- aligned_valid  out  1  aligned_data valid this cycle
- aligned_data  out  10  aligned symbol; bit 9 = a … bit 0 = j
- comma_det  out  1  aligned_data is K28.5 (qualified by aligned_valid)
- aligned  out  1  lock flag
- offset  out  4  locked bit offset 0..9

Behaviour:
- Reset (rst_n low at posedge):
  - state HUNT; prev word, counters and candidate offset 0.
  - All outputs 0.
- Window and candidates:
  - On each rx_valid cycle, window[19:0] = {prev, rx_data}; prev <= rx_data.
  - Candidate o (0..9) = window[19-o : 10-o].
  - K28.5 match is an exact 10-bit match: 0011111010 (RD-) or 1100000101 (RD+).
  - If several offsets match, the lowest offset is used.
- rx_valid low: no window shift, no FSM or counter change, aligned_valid <= 0.
- FSM (evaluated only on rx_valid cycles):
  - HUNT:
    - K28.5 at offset o: cand <= o, cnt <= 1, go to VERIFY.
    - If LOCK_CNT == 1, go straight to LOCKED instead.
    - No match: stay in HUNT.
  - VERIFY:
    - Match at cand: cnt++.
    - When cnt reaches LOCK_CNT: go to LOCKED, offset <= cand, miscnt <= 0.
    - Match at a different offset only: cand <= new, cnt <= 1.
    - No match anywhere: go to HUNT, cnt <= 0.
  - LOCKED:
    - Match at the locked offset: miscnt <= 0.
    - Match only at a foreign offset: miscnt++.
    - When miscnt reaches LOSS_CNT: go to HUNT, aligned <= 0. The triggering word does not seed a new candidate.
    - Non-comma words do not change miscnt.
- realign:
  - From any state, realign = 1 forces HUNT, clears cnt and miscnt, and sets aligned <= 0, aligned_valid <= 0 next cycle.
  - realign has priority over a same-cycle rx_valid word. That word still shifts into prev but is not evaluated.
- Outputs (all registered, latency 1 from the accepting rx_valid cycle):
  - aligned_valid <= rx_valid and next-state is LOCKED.
  - aligned_data <= candidate at the next-state offset.
  - comma_det <= aligned_valid-qualified K28.5 match on that candidate.
  - The word completing lock is itself emitted: it is the first aligned_valid beat, with aligned = 1.
  - When not valid, aligned_data holds its last value and comma_det = 0.
  - offset updates only on entry to LOCKED and holds through HUNT and VERIFY until the next lock.
- Counters saturate at 15; no wrap.

Test Plan:
- Reset: drive rst_n = 0 for 2 cycles with random rx_data and rx_valid = 1 -> all outputs 0, no lock.
- Lock at offset 3: continuous alternating K28.5 RD-/RD+ stream skewed by 3 bits, rx_valid = 1 -> the 4th K28.5 completing in the window sets aligned = 1 and offset = 3 one cycle later.
  - aligned_data alternates 0011111010 / 1100000101 with comma_det = 1.
  - Then D21.5 data (1010101010) is emitted with comma_det = 0.
- VERIFY interruption: 3 K28.5 at offset 5, then 1 non-comma word -> aligned stays 0; 4 further K28.5 are needed before aligned = 1 with offset = 5.
- Valid gaps: 4 K28.5 at offset 7, with rx_valid low for 2 cycles between the 2nd and 3rd -> lock on the 4th valid word, offset = 7; aligned_valid = 0 during the gaps.
- Loss and relock: locked at 3, then K28.5 shifted to offset 8 -> aligned drops after the 4th foreign comma; relock with offset = 8 after 4 further commas (8 foreign commas total).
  - An intervening comma at offset 3 resets miscnt and keeps lock.
- Forced realign: pulse realign while LOCKED with commas streaming at offset 2 -> aligned = 0 and aligned_valid = 0 the next cycle; relock at offset 2 after 4 subsequent commas.
